pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Runs on the PLL output clock and turns the raw PLL lock flag into a clean system reset.
//  Lock is synchronised and qualified over a programmable window, then reset is held off.
//  Once running, it generates NUM_CH runtime-programmable clock-enable strobes for slower logic.
//  Loss of lock forces the system back into reset, and each loss is recorded and counted.
// PARAMETERS
//  LOCK_CYCLES  1024  consecutive synchronised-locked cycles needed to qualify lock (>=1)
//  RESET_HOLD   16    cycles sys_reset stays high after lock is qualified (>=1)
//  NUM_CH       2     number of clock-enable channels (>=1)
//  DIV_W        8     width of each channel divisor
// PORTS
//  clock_in    in   1             PLL output clock; only clock in the block
//  reset       in   1             asynchronous, active-high reset
//  locked      in   1             raw PLL lock flag, asynchronous to clock_in
//  div_load    in   1             1-cycle strobe: capture div_value into pending divisors
//  div_value   in   NUM_CH*DIV_W  channel i divisor = div_value[i*DIV_W +: DIV_W]
//  lost_clear  in   1             clears lock_lost
//  sys_reset   out  1             system reset, active high
//  ready       out  1             high while in RUN
//  clk_en      out  NUM_CH        per-channel enable strobes
//  lock_lost   out  1             sticky flag: lock was lost while in RUN
//  lost_count  out  8             count of losses from RUN, saturates at 255
// BEHAVIOUR
//  Reset (async, takes effect immediately with no clock edge):
//   state=WAIT_LOCK, sys_reset=1, ready=0, clk_en=0, lock_lost=0, lost_count=0.
//   Sync flops=0, all counters=0, active and pending divisors=1.
//  Sync: locked passes through 2 flops to give locked_s; only locked_s is used.
//  FSM, one transition per clock_in edge:
//   WAIT_LOCK: locked_s=1 -> QUALIFY, counter cleared.
//   QUALIFY: locked_s=0 -> WAIT_LOCK. After LOCK_CYCLES cycles in QUALIFY -> HOLD.
//   HOLD: locked_s=0 -> WAIT_LOCK. After RESET_HOLD cycles in HOLD -> RUN.
//   RUN: locked_s=0 -> WAIT_LOCK; on that edge set lock_lost and increment lost_count (sat 255).
//  Outputs are registered with the state; ready=(state==RUN) and sys_reset=!ready.
//   The ready rise and sys_reset fall happen on the same edge.
//  Latency: if locked is high before edge 0, ready=1 after edge 3+LOCK_CYCLES+RESET_HOLD.
//   Loss of lock: locked low before edge k gives sys_reset=1, ready=0, clk_en=0 after edge k+2.
//  A 1-cycle locked_s dropout in QUALIFY or HOLD restarts the full qualification; no partial credit.
//  Divider channel i uses an active divisor D (value 0 is treated as 1) and a counter c_i.
//   Counter width is DIV_W.
//   Outside RUN: c_i=0 and clk_en[i]=0.
//   In RUN: clk_en[i]=(c_i==0). c_i counts up and wraps 0..D-1.
//   The first RUN cycle therefore has clk_en=1 on every channel.
//   D=1: clk_en[i] stays high for all of RUN.
//  Divisor update:
//   div_load copies div_value into the pending regs.
//   Active is loaded from pending on each cycle where c_i wraps to 0, and on RUN entry.
//   div_load on the same edge as a wrap: the new value is used for the period starting at that wrap.
//   The pending divisor survives lock loss and is not reset by it; only reset restores 1.
//  lost_clear clears lock_lost on the next edge.
//   lost_clear on the same edge as a loss: set wins, lock_lost=1.
//   lost_count is not cleared by lost_clear; only reset clears it.
//  Counter widths:
//   qualify counter uses $clog2(LOCK_CYCLES+1) bits; hold counter uses $clog2(RESET_HOLD+1) bits.
//   Neither counter wraps; both clear on any state entry.
// TESTING (LOCK_CYCLES=4, RESET_HOLD=2, NUM_CH=2, DIV_W=8 unless noted)
//  1. Reset, locked=1 before edge 0, divisors 1 and 3 loaded before lock
//     -> ready=1, sys_reset=0 after edge 9.
//     clk_en[0] then stays 1; clk_en[1] repeats 1,0,0.
//  2. locked drops for one cycle while in QUALIFY
//     -> back to WAIT_LOCK, then a full 4+2 cycles are needed again; sys_reset stays 1 throughout.
//  3. locked falls during RUN
//     -> 2 edges later: sys_reset=1, ready=0, clk_en=00, lock_lost=1, lost_count=1.
//     Repeating this 300 times -> lost_count=255.
//  4. In RUN, ch1 D=3, div_load value 5 at c_1=1
//     -> current period completes with 3 cycles, then the strobe period is 5.
//     Loading 0 -> strobe every cycle.
//  5. reset pulsed between edges during RUN
//     -> sys_reset=1, ready=0, clk_en=0, lock_lost=0, divisors=1 before the next edge.
//  6. lost_clear asserted on the same edge as a RUN lock loss -> lock_lost=1, lost_count increments.

Source files
------------

// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and the logic around it.
// The slave side is the sequencer; the master side drives lock, divisor and clear inputs.
interface pll_reset_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8
);
    logic                    locked;
    logic                    div_load;
    logic [NUM_CH*DIV_W-1:0] div_value;
    logic                    lost_clear;
    logic                    sys_reset;
    logic                    ready;
    logic [NUM_CH-1:0]       clk_en;
    logic                    lock_lost;
    logic [7:0]              lost_count;

    modport slave (
        input  locked,
        input  div_load,
        input  div_value,
        input  lost_clear,
        output sys_reset,
        output ready,
        output clk_en,
        output lock_lost,
        output lost_count
    );

    modport master (
        output locked,
        output div_load,
        output div_value,
        output lost_clear,
        input  sys_reset,
        input  ready,
        input  clk_en,
        input  lock_lost,
        input  lost_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: qualifies the PLL lock flag, releases system reset after a hold
// period and generates programmable clock-enable strobes while running.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WAIT_LOCK | system in reset, waiting for synchronised lock
// QUALIFY   | lock seen, counting LOCK_CYCLES consecutive locked cycles
// HOLD      | lock qualified, keeping sys_reset high for RESET_HOLD cycles
// RUN       | sys_reset released, ready high, clock-enable dividers active
module pll_reset_sequencer #(
    parameter int LOCK_CYCLES = 1024,
    parameter int RESET_HOLD  = 16,
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8
) (
    input  logic                 clock_in,
    input  logic                 reset,
    pll_reset_sequencer_if.slave bus
);
    localparam int QW = $clog2(LOCK_CYCLES + 1);
    localparam int HW = $clog2(RESET_HOLD + 1);
    localparam logic [QW-1:0] QUAL_DONE = QW'(LOCK_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [1:0]                     sync_q;
    logic                           locked_s;
    logic [QW-1:0]                  qual_cnt_q, qual_cnt_d;
    logic [HW-1:0]                  hold_cnt_q, hold_cnt_d;
    logic                           ready_q, ready_d;
    logic [NUM_CH-1:0]              clk_en_q, clk_en_d;
    logic                           lock_lost_q, lock_lost_d;
    logic [7:0]                     lost_count_q, lost_count_d;
    logic                           loss;
    logic [NUM_CH-1:0][DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   div_act_q, div_act_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   div_pend_q, div_pend_d;

    // Last counter value of a period; a divisor of 0 behaves like 1.
    function automatic logic [DIV_W-1:0] period_last(input logic [DIV_W-1:0] d);
        return (d == '0) ? '0 : d - DIV_W'(1);
    endfunction

    assign locked_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.locked};
        end
    end

    // Next state and qualify/hold counters; counters sit at zero except while counting.
    always_comb begin
        state_d    = state_q;
        qual_cnt_d = '0;
        hold_cnt_d = '0;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) state_d = QUALIFY;
            end
            QUALIFY: begin
                if (!locked_s)                    state_d = WAIT_LOCK;
                else if (qual_cnt_q == QUAL_DONE) state_d = HOLD;
                else                              qual_cnt_d = qual_cnt_q + QW'(1);
            end
            HOLD: begin
                if (!locked_s)                    state_d = WAIT_LOCK;
                else if (hold_cnt_q == HOLD_LAST) state_d = RUN;
                else                              hold_cnt_d = hold_cnt_q + HW'(1);
            end
            RUN: begin
                if (!locked_s) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Loss bookkeeping: a loss on the same edge as a clear keeps the flag set.
    always_comb begin
        loss         = (state_q == RUN) && !locked_s;
        lock_lost_d  = lock_lost_q;
        lost_count_d = lost_count_q;
        if (loss) begin
            lock_lost_d = 1'b1;
            if (lost_count_q != 8'hFF) lost_count_d = lost_count_q + 8'd1;
        end else if (bus.lost_clear) begin
            lock_lost_d = 1'b0;
        end
    end

    // Divider channels: reload the active divisor on RUN entry and on every wrap.
    always_comb begin
        div_pend_d = div_pend_q;
        div_act_d  = div_act_q;
        div_cnt_d  = '0;
        clk_en_d   = '0;
        ready_d    = (state_d == RUN);
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.div_load) div_pend_d[i] = bus.div_value[i*DIV_W +: DIV_W];
            if (state_d == RUN) begin
                if (state_q != RUN || div_cnt_q[i] == period_last(div_act_q[i])) begin
                    div_act_d[i] = div_pend_d[i];
                    div_cnt_d[i] = '0;
                end else begin
                    div_cnt_d[i] = div_cnt_q[i] + DIV_W'(1);
                end
                clk_en_d[i] = (div_cnt_d[i] == '0);
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_LOCK;
            qual_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            ready_q      <= 1'b0;
            clk_en_q     <= '0;
            lock_lost_q  <= 1'b0;
            lost_count_q <= '0;
            div_cnt_q    <= '0;
            div_act_q    <= {NUM_CH{DIV_W'(1)}};
            div_pend_q   <= {NUM_CH{DIV_W'(1)}};
        end else begin
            state_q      <= state_d;
            qual_cnt_q   <= qual_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            ready_q      <= ready_d;
            clk_en_q     <= clk_en_d;
            lock_lost_q  <= lock_lost_d;
            lost_count_q <= lost_count_d;
            div_cnt_q    <= div_cnt_d;
            div_act_q    <= div_act_d;
            div_pend_q   <= div_pend_d;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.sys_reset  = ~ready_q;
    assign bus.clk_en     = clk_en_q;
    assign bus.lock_lost  = lock_lost_q;
    assign bus.lost_count = lost_count_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for the PLL reset sequencer: directed stimulus pushes expected output snapshots
// tagged with the clock edge they belong to; a monitor compares them on the falling edge.
module tb_pll_reset_sequencer;
    logic clock_in = 1'b0;
    logic reset    = 1'b1;
    int   ecnt     = 0;

    pll_reset_sequencer_if #(.NUM_CH(2), .DIV_W(8)) bus ();

    pll_reset_sequencer #(
        .LOCK_CYCLES(4),
        .RESET_HOLD (2),
        .NUM_CH     (2),
        .DIV_W      (8)
    ) dut (
        .clock_in(clock_in),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clock_in = ~clock_in;
    always @(posedge clock_in) ecnt <= ecnt + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic       sr;
        logic       rd;
        logic [1:0] en;
        logic       en_care;
        logic       ll;
        logic [7:0] lc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       exp_lost = 1'b0;
    logic [7:0] exp_cnt  = 8'd0;

    function automatic void push(input int c, input string nm, input logic sr, input logic rd,
                                 input logic [1:0] en, input logic care);
        exp_t e;
        e.cyc = c; e.name = nm; e.sr = sr; e.rd = rd; e.en = en; e.en_care = care;
        e.ll = exp_lost; e.lc = exp_cnt;
        sb.push_back(e);
    endfunction

    task automatic wait_cyc(input int c);
        while (ecnt < c) @(negedge clock_in);
    endtask

    // Raise lock now; ready is expected 10 edges later with the given first strobes.
    task automatic lock_up(input logic [1:0] en1, output int rdy);
        int b;
        b = ecnt;
        bus.locked = 1'b1;
        push(b + 9, "hold_before_run", 1'b1, 1'b0, 2'b00, 1'b1);
        push(b + 10, "run_entry", 1'b0, 1'b1, en1, 1'b1);
        rdy = b + 10;
    endtask

    // Drop lock now; the sequencer falls back to reset three edges later.
    task automatic lose(input logic with_clear);
        int b;
        b = ecnt;
        bus.locked = 1'b0;
        push(b + 2, "still_running", 1'b0, 1'b1, 2'b00, 1'b0);
        wait_cyc(b + 2);
        if (with_clear) bus.lost_clear = 1'b1;
        exp_lost = 1'b1;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        push(b + 3, with_clear ? "loss_with_clear" : "loss", 1'b1, 1'b0, 2'b00, 1'b1);
        wait_cyc(b + 3);
        bus.lost_clear = 1'b0;
    endtask

    // Monitor: compare every snapshot due at the current edge.
    initial begin
        forever begin
            @(negedge clock_in);
            while (sb.size() > 0 && sb[0].cyc <= ecnt) begin
                mon_e = sb.pop_front();
                n_checks++;
                if (mon_e.cyc < ecnt) begin
                    n_fail++;
                    $display("FAIL %s: due at edge %0d but not checked until edge %0d",
                             mon_e.name, mon_e.cyc, ecnt);
                end else if (bus.sys_reset !== mon_e.sr || bus.ready !== mon_e.rd ||
                             (mon_e.en_care && bus.clk_en !== mon_e.en) ||
                             bus.lock_lost !== mon_e.ll || bus.lost_count !== mon_e.lc) begin
                    n_fail++;
                    $display("FAIL %s @edge %0d: got sr=%b rd=%b en=%b ll=%b lc=%0d, expected sr=%b rd=%b en=%b(care=%b) ll=%b lc=%0d",
                             mon_e.name, ecnt, bus.sys_reset, bus.ready, bus.clk_en, bus.lock_lost,
                             bus.lost_count, mon_e.sr, mon_e.rd, mon_e.en, mon_e.en_care,
                             mon_e.ll, mon_e.lc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", ecnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, f0, rdy, n;
        bus.locked     = 1'b0;
        bus.div_load   = 1'b0;
        bus.div_value  = '0;
        bus.lost_clear = 1'b0;
        repeat (2) @(negedge clock_in);
        push(ecnt + 1, "reset_state", 1'b1, 1'b0, 2'b00, 1'b1);
        @(negedge clock_in);
        reset = 1'b0;
        @(negedge clock_in);

        // Lock with divisors 1 and 3 loaded on the first edge.
        e0 = ecnt + 1;
        bus.div_load  = 1'b1;
        bus.div_value = {8'd3, 8'd1};
        push(e0 + 5, "qualifying", 1'b1, 1'b0, 2'b00, 1'b1);
        lock_up(2'b11, rdy);
        push(e0 + 10, "div3_e10", 1'b0, 1'b1, 2'b01, 1'b1);
        push(e0 + 11, "div3_e11", 1'b0, 1'b1, 2'b01, 1'b1);
        @(negedge clock_in);
        bus.div_load = 1'b0;

        // Load 5 on ch1 while its counter is 1: current period finishes at 3, then 5.
        push(e0 + 12, "div3_tail", 1'b0, 1'b1, 2'b11, 1'b1);
        push(e0 + 13, "div5_a", 1'b0, 1'b1, 2'b01, 1'b1);
        push(e0 + 16, "div5_b", 1'b0, 1'b1, 2'b01, 1'b1);
        push(e0 + 17, "div5_strobe", 1'b0, 1'b1, 2'b11, 1'b1);
        push(e0 + 18, "div5_c", 1'b0, 1'b1, 2'b01, 1'b1);
        push(e0 + 21, "div5_d", 1'b0, 1'b1, 2'b01, 1'b1);
        push(e0 + 22, "div5_strobe2", 1'b0, 1'b1, 2'b11, 1'b1);
        wait_cyc(e0 + 10);
        bus.div_load  = 1'b1;
        bus.div_value = {8'd5, 8'd1};
        @(negedge clock_in);
        bus.div_load = 1'b0;

        // Load 0: takes effect at the next wrap, then strobes every cycle.
        push(e0 + 23, "div0_a", 1'b0, 1'b1, 2'b01, 1'b1);
        push(e0 + 26, "div0_b", 1'b0, 1'b1, 2'b01, 1'b1);
        push(e0 + 27, "div0_c", 1'b0, 1'b1, 2'b11, 1'b1);
        push(e0 + 28, "div0_d", 1'b0, 1'b1, 2'b11, 1'b1);
        push(e0 + 29, "div0_e", 1'b0, 1'b1, 2'b11, 1'b1);
        wait_cyc(e0 + 22);
        bus.div_load  = 1'b1;
        bus.div_value = {8'd0, 8'd1};
        @(negedge clock_in);
        bus.div_load = 1'b0;

        // Load 2 on the same edge as a wrap: new period starts at that wrap.
        push(e0 + 30, "wrap_load_a", 1'b0, 1'b1, 2'b11, 1'b1);
        push(e0 + 31, "wrap_load_b", 1'b0, 1'b1, 2'b01, 1'b1);
        push(e0 + 32, "wrap_load_c", 1'b0, 1'b1, 2'b11, 1'b1);
        wait_cyc(e0 + 29);
        bus.div_load  = 1'b1;
        bus.div_value = {8'd2, 8'd1};
        @(negedge clock_in);
        bus.div_load = 1'b0;

        // Single loss of lock from RUN, then a plain clear.
        wait_cyc(e0 + 33);
        lose(1'b0);
        wait_cyc(ecnt + 1);
        bus.lost_clear = 1'b1;
        exp_lost = 1'b0;
        push(ecnt + 1, "lost_clear", 1'b1, 1'b0, 2'b00, 1'b1);
        @(negedge clock_in);
        bus.lost_clear = 1'b0;

        // Relock: pending divisor 2 on ch1 survived the loss.
        wait_cyc(ecnt + 2);
        lock_up(2'b11, rdy);
        push(rdy + 1, "pend_kept_a", 1'b0, 1'b1, 2'b01, 1'b1);
        push(rdy + 2, "pend_kept_b", 1'b0, 1'b1, 2'b11, 1'b1);
        wait_cyc(rdy + 3);

        // Loss with lost_clear on the same edge: set wins.
        lose(1'b1);

        // One-cycle dropout during QUALIFY restarts the whole qualification.
        wait_cyc(ecnt + 2);
        f0 = ecnt + 1;
        bus.locked = 1'b1;
        push(f0 + 5, "dropout_a", 1'b1, 1'b0, 2'b00, 1'b1);
        push(f0 + 9, "dropout_b", 1'b1, 1'b0, 2'b00, 1'b1);
        push(f0 + 13, "dropout_c", 1'b1, 1'b0, 2'b00, 1'b1);
        push(f0 + 14, "dropout_run", 1'b0, 1'b1, 2'b11, 1'b1);
        push(f0 + 15, "dropout_run_b", 1'b0, 1'b1, 2'b01, 1'b1);
        wait_cyc(f0 + 3);
        bus.locked = 1'b0;
        @(negedge clock_in);
        bus.locked = 1'b1;
        wait_cyc(f0 + 15);

        // Repeated losses saturate the counter at 255.
        for (int i = 0; i < 300; i++) begin
            lose(1'b0);
            lock_up(2'b11, rdy);
            wait_cyc(rdy);
        end

        // Asynchronous reset pulse between edges while running.
        @(posedge clock_in);
        #2;
        n = ecnt;
        exp_lost = 1'b0;
        exp_cnt  = 8'd0;
        push(n, "async_reset", 1'b1, 1'b0, 2'b00, 1'b1);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        push(n + 10, "reset_relock", 1'b0, 1'b1, 2'b11, 1'b1);
        push(n + 11, "reset_div1_a", 1'b0, 1'b1, 2'b11, 1'b1);
        push(n + 12, "reset_div1_b", 1'b0, 1'b1, 2'b11, 1'b1);
        wait_cyc(n + 13);
        @(negedge clock_in);

        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation for edge %0d never compared (now %0d)",
                     mon_e.name, mon_e.cyc, ecnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
